io_port_bank: RTL and testbench
===============================

// Module: io_port_bank
// PURPOSE
//  Multi-channel successor to the single InPort/OutPort pair on the CPU datapath bus.
//  Provides NUM_CH input channels, each with a FIFO_DEPTH first-word-fall-through FIFO,
//  and NUM_CH output channels, each with a holding register and valid/ack handshake.
//  The CPU side is driven by the control unit (OutPortIn / InPortOut, channel from ch_sel).
// PARAMETERS
//  DATA_WIDTH  32  width of the bus and of every channel word
//  NUM_CH      4   number of input channels and number of output channels (>=1)
//  FIFO_DEPTH  8   entries per input FIFO; power of 2, >=2
// PORTS
//  Clock        in   1              system clock, all state on rising edge
//  Clear        in   1              asynchronous, active-low reset
//  BusMuxOut    in   DATA_WIDTH     CPU bus value written to the selected output channel
//  ch_sel       in   $clog2(NUM_CH) channel index for OutPortIn / InPortOut (min width 1)
//  OutPortIn    in   1              load BusMuxOut into output channel ch_sel
//  InPortOut    in   1              pop input channel ch_sel onto InPort_q
//  InPort_q     out  DATA_WIDTH     head of input FIFO ch_sel; 0 when that FIFO is empty
//  in_data      in   NUM_CH*DW      packed external input words, channel c at [c*DW +: DW]
//  in_valid     in   NUM_CH         external producer offers in_data[c]
//  in_ready     out  NUM_CH         FIFO c not full
//  out_data     out  NUM_CH*DW      packed output registers
//  out_valid    out  NUM_CH         output channel c holds an unacknowledged word
//  out_ack      in   NUM_CH         external consumer accepts out_data[c]
//  in_empty     out  NUM_CH         FIFO c empty
//  flags        out  3*NUM_CH       sticky {underflow, overflow, overrun}, per channel
//  clr_flags    in   1              synchronous clear of all sticky flags
// BEHAVIOUR
//  Reset (Clear=0, async): pointers/counts 0, all FIFOs empty, out_data=0, out_valid=0,
//   flags=0, in_ready=all 1, in_empty=all 1, InPort_q=0, irq=0.
//  Input FIFO c: push on edge when in_valid[c]&in_ready[c]; count width $clog2(DEPTH)+1;
//   pointers wrap modulo FIFO_DEPTH. in_valid[c] while full -> word dropped, overflow[c]=1.
//  InPort_q combinational (FWFT) from ch_sel head; pop on edge when InPortOut & !empty.
//   InPortOut on empty channel -> no pop, InPort_q=0, underflow[ch_sel]=1.
//  Push+pop same edge, same FIFO: count unchanged; when empty, push only (pop = underflow).
//   When full, in_ready=0 that cycle, so push is refused even if popping.
//  Output channel c FSM: IDLE (valid=0) / PEND (valid=1).
//   IDLE + OutPortIn(c): load out_data[c], -> PEND; out_valid rises 1 cycle after strobe.
//   PEND + out_ack[c]: -> IDLE. PEND + OutPortIn(c) without ack: overwrite data,
//   stay PEND, overrun[c]=1. PEND + ack + OutPortIn(c) same edge: load new word, stay
//   PEND, no overrun. out_ack in IDLE ignored.
//  OutPortIn and InPortOut may assert together; both act on ch_sel independently.
//  ch_sel >= NUM_CH: strobes ignored, InPort_q=0, no flag change.
//  clr_flags and a new flag event on the same edge: event wins (flag set).
//  Reset mid-transfer discards FIFO contents and any pending output word.
// CONFIGURATION
//  PORT_IRQ_EN defined: adds ports irq_mask (in, NUM_CH) and irq (out, 1, registered):
//   irq <= |(~in_empty & irq_mask) | (|flags); reset 0; one-cycle latency.
//  PORT_IRQ_EN undefined: irq and irq_mask ports absent; no interrupt logic.
// TESTING
//  1 reset: Clear low mid-run -> out_valid=0, in_empty=4'hF, flags=0, InPort_q=0 at once.
//  2 push 8 words 0xA0..0xA7 on ch2 -> in_ready[2]=0; 9th (0xA8) dropped, overflow[2]=1;
//    8 InPortOut pops with ch_sel=2 return 0xA0..0xA7 in order, then in_empty[2]=1.
//  3 InPortOut ch_sel=1 while empty -> InPort_q=0, underflow[1]=1; clr_flags -> 0.
//  4 OutPortIn ch0, bus=0x12345678 -> out_valid[0]=1 next cycle, data held until
//    out_ack[0]; second write 0xDEAD before ack -> out_data=0xDEAD, overrun[0]=1.
//  5 ack and OutPortIn ch3 same edge (0x55) -> out_valid[3] stays 1, data 0x55, no overrun.
//  6 PORT_IRQ_EN, irq_mask=4'b0100, push one word on ch2 -> irq=1 one cycle later; pop -> 0.

Source files
------------

// File: rtl/io_port_bank_if.sv
// CPU-side and channel-side signal bundle for io_port_bank.
// The slave modport is the bank; master is the control unit plus the external channel agents.
interface io_port_bank_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 4
);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [DATA_WIDTH-1:0]        BusMuxOut;
  logic [CW-1:0]                ch_sel;
  logic                         OutPortIn;
  logic                         InPortOut;
  logic [DATA_WIDTH-1:0]        InPort_q;
  logic [NUM_CH*DATA_WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]            in_valid;
  logic [NUM_CH-1:0]            in_ready;
  logic [NUM_CH*DATA_WIDTH-1:0] out_data;
  logic [NUM_CH-1:0]            out_valid;
  logic [NUM_CH-1:0]            out_ack;
  logic [NUM_CH-1:0]            in_empty;
  logic [3*NUM_CH-1:0]          flags;
  logic                         clr_flags;

  modport slave (
    input  BusMuxOut, ch_sel, OutPortIn, InPortOut, in_data, in_valid, out_ack, clr_flags,
    output InPort_q, in_ready, out_data, out_valid, in_empty, flags
  );

  modport master (
    output BusMuxOut, ch_sel, OutPortIn, InPortOut, in_data, in_valid, out_ack, clr_flags,
    input  InPort_q, in_ready, out_data, out_valid, in_empty, flags
  );
endinterface

// File: rtl/io_port_bank.sv
// NUM_CH FWFT input FIFOs and NUM_CH handshaked output registers on the CPU datapath bus.
// Optional interrupt output (irq, irq_mask) when PORT_IRQ_EN is defined.
module io_port_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             Clock,
  input  logic             Clear,
  io_port_bank_if.slave    bus
`ifdef PORT_IRQ_EN
  ,
  input  logic [NUM_CH-1:0] irq_mask,
  output logic              irq
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = DATA_WIDTH;

  typedef enum logic {IDLE, PEND} ost_e;

  logic                           sel_ok;
  logic [NUM_CH-1:0]              sel_oh;
  logic [NUM_CH-1:0][DW-1:0]      head_w;
  logic [NUM_CH-1:0][DW-1:0]      odat_w;
  logic [NUM_CH-1:0][2:0]         flags_w;
  logic [NUM_CH-1:0]              rdy_w, empty_w, oval_w;

  // Out-of-range channel selects make every strobe a no-op.
  assign sel_ok = int'(bus.ch_sel) < NUM_CH;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [DW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q;
    logic          full, empty, push, pop, ovf_ev, udf_ev, wr, ovr_ev;
    ost_e          ost_q, ost_d;
    logic [DW-1:0] odat_q, odat_d;
    logic [2:0]    flg_q;

    assign sel_oh[c] = sel_ok && (int'(bus.ch_sel) == c);
    assign full      = cnt_q == (AW+1)'(FIFO_DEPTH);
    assign empty     = cnt_q == '0;
    // A full FIFO refuses the push even when the same edge pops.
    assign push      = bus.in_valid[c] & ~full;
    assign pop       = bus.InPortOut & sel_oh[c] & ~empty;
    assign ovf_ev    = bus.in_valid[c] & full;
    assign udf_ev    = bus.InPortOut & sel_oh[c] & empty;
    assign wr        = bus.OutPortIn & sel_oh[c];

    always_ff @(posedge Clock or negedge Clear) begin
      if (!Clear) begin
        wptr_q <= '0;
        rptr_q <= '0;
        cnt_q  <= '0;
      end else begin
        if (push) wptr_q <= wptr_q + 1'b1;
        if (pop)  rptr_q <= rptr_q + 1'b1;
        if (push && !pop)      cnt_q <= cnt_q + 1'b1;
        else if (pop && !push) cnt_q <= cnt_q - 1'b1;
      end
    end

    always_ff @(posedge Clock) begin
      if (push) mem_q[wptr_q] <= bus.in_data[c*DW +: DW];
    end

    always_comb begin
      ost_d  = ost_q;
      odat_d = odat_q;
      ovr_ev = 1'b0;
      case (ost_q)
        IDLE: if (wr) begin
          odat_d = bus.BusMuxOut;
          ost_d  = PEND;
        end
        PEND: if (wr) begin
          odat_d = bus.BusMuxOut;
          ovr_ev = ~bus.out_ack[c];
        end else if (bus.out_ack[c]) begin
          ost_d  = IDLE;
        end
        default: ost_d = IDLE;
      endcase
    end

    always_ff @(posedge Clock or negedge Clear) begin
      if (!Clear) begin
        ost_q  <= IDLE;
        odat_q <= '0;
        flg_q  <= '0;
      end else begin
        ost_q  <= ost_d;
        odat_q <= odat_d;
        // A flag event on the clearing edge still sets the flag.
        flg_q  <= (bus.clr_flags ? 3'b000 : flg_q) | {udf_ev, ovf_ev, ovr_ev};
      end
    end

    assign head_w[c]  = empty ? '0 : mem_q[rptr_q];
    assign rdy_w[c]   = ~full;
    assign empty_w[c] = empty;
    assign oval_w[c]  = ost_q == PEND;
    assign odat_w[c]  = odat_q;
    assign flags_w[c] = flg_q;
  end

  assign bus.InPort_q  = sel_ok ? head_w[bus.ch_sel] : '0;
  assign bus.in_ready  = rdy_w;
  assign bus.in_empty  = empty_w;
  assign bus.out_valid = oval_w;
  assign bus.out_data  = odat_w;
  assign bus.flags     = flags_w;

`ifdef PORT_IRQ_EN
  logic irq_q;
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) irq_q <= 1'b0;
    else        irq_q <= (|(~empty_w & irq_mask)) | (|flags_w);
  end
  assign irq = irq_q;
`endif
endmodule

// File: tb/tb_io_port_bank.sv
// Randomized and directed checks of io_port_bank against a queue-based reference model.
module tb_io_port_bank;
  localparam int DW = 32, NC = 4, DEPTH = 8;

  logic Clock = 1'b0;
  logic Clear;
  always #5 Clock = ~Clock;

  io_port_bank_if #(.DATA_WIDTH(DW), .NUM_CH(NC)) bif();
`ifdef PORT_IRQ_EN
  logic [NC-1:0] irq_mask;
  logic          irq;
`endif

  io_port_bank #(.DATA_WIDTH(DW), .NUM_CH(NC), .FIFO_DEPTH(DEPTH)) dut (
    .Clock (Clock),
    .Clear (Clear),
    .bus   (bif)
`ifdef PORT_IRQ_EN
    ,
    .irq_mask (irq_mask),
    .irq      (irq)
`endif
  );

  typedef logic [DW-1:0] word_q_t[$];
  word_q_t       mq [NC];
  logic          m_oval [NC];
  logic [DW-1:0] m_odat [NC];
  logic [2:0]    m_flg  [NC];
  logic          m_irq;
  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      mq[c].delete();
      m_oval[c] = 1'b0;
      m_odat[c] = '0;
      m_flg[c]  = '0;
    end
    m_irq = 1'b0;
  endtask

  task automatic idle();
    bif.OutPortIn = 1'b0;
    bif.InPortOut = 1'b0;
    bif.in_valid  = '0;
    bif.out_ack   = '0;
    bif.clr_flags = 1'b0;
  endtask

  task automatic model_check();
    logic [NC-1:0]      e_rdy, e_emp, e_oval;
    logic [NC*DW-1:0]   e_odat;
    logic [3*NC-1:0]    e_flg;
    logic [DW-1:0]      e_inq;
    int ch;
    ch = int'(bif.ch_sel);
    for (int c = 0; c < NC; c++) begin
      e_rdy[c]            = mq[c].size() < DEPTH;
      e_emp[c]            = mq[c].size() == 0;
      e_oval[c]           = m_oval[c];
      e_odat[c*DW +: DW]  = m_odat[c];
      e_flg[3*c +: 3]     = m_flg[c];
    end
    e_inq = (ch < NC && mq[ch].size() > 0) ? mq[ch][0] : '0;
    chk("in_ready",  128'(bif.in_ready),  128'(e_rdy));
    chk("in_empty",  128'(bif.in_empty),  128'(e_emp));
    chk("out_valid", 128'(bif.out_valid), 128'(e_oval));
    chk("out_data",  128'(bif.out_data),  128'(e_odat));
    chk("flags",     128'(bif.flags),     128'(e_flg));
    chk("InPort_q",  128'(bif.InPort_q),  128'(e_inq));
`ifdef PORT_IRQ_EN
    chk("irq", 128'(irq), 128'(m_irq));
`endif
  endtask

  task automatic model_step();
    logic [2:0] ev;
    logic       sel, full, nirq;
    nirq = 1'b0;
`ifdef PORT_IRQ_EN
    for (int c = 0; c < NC; c++)
      if ((mq[c].size() > 0 && irq_mask[c]) || m_flg[c] != 3'b000) nirq = 1'b1;
`endif
    for (int c = 0; c < NC; c++) begin
      ev   = '0;
      sel  = int'(bif.ch_sel) == c;
      full = mq[c].size() == DEPTH;
      if (bif.InPortOut && sel && mq[c].size() == 0) ev[2] = 1'b1;
      if (bif.in_valid[c] && full) ev[1] = 1'b1;
      if (bif.InPortOut && sel && mq[c].size() > 0) void'(mq[c].pop_front());
      if (bif.in_valid[c] && !full) mq[c].push_back(bif.in_data[c*DW +: DW]);
      if (bif.OutPortIn && sel) begin
        if (m_oval[c] && !bif.out_ack[c]) ev[0] = 1'b1;
        m_odat[c] = bif.BusMuxOut;
        m_oval[c] = 1'b1;
      end else if (bif.out_ack[c]) begin
        m_oval[c] = 1'b0;
      end
      m_flg[c] = (bif.clr_flags ? 3'b000 : m_flg[c]) | ev;
    end
    m_irq = nirq;
  endtask

  task automatic cyc();
    @(negedge Clock);
    model_check();
    model_step();
    @(posedge Clock);
    #1;
  endtask

  // Asynchronous reset asserted between edges; outputs must clear immediately.
  task automatic async_reset();
    #2 Clear = 1'b0;
    idle();
    #1;
    model_reset();
    model_check();
    @(negedge Clock);
    Clear = 1'b1;
    @(posedge Clock);
    #1;
  endtask

  initial begin
    Clear = 1'b0;
    idle();
    bif.ch_sel    = '0;
    bif.BusMuxOut = '0;
    bif.in_data   = '0;
`ifdef PORT_IRQ_EN
    irq_mask = '0;
`endif
    model_reset();
    #7;
    model_check();
    @(negedge Clock);
    Clear = 1'b1;
    @(posedge Clock);
    #1;

    // Fill ch2 to full, then one extra word that must be dropped.
    for (int i = 0; i < 9; i++) begin
      bif.in_valid = 4'b0100;
      bif.in_data[2*DW +: DW] = 32'hA0 + i;
      if (i == 8) chk("full_ready2", 128'(bif.in_ready[2]), 128'(0));
      cyc();
    end
    idle();
    chk("overflow2", 128'(bif.flags[7]), 128'(1));
    for (int i = 0; i < 8; i++) begin
      bif.ch_sel = 2'd2;
      bif.InPortOut = 1'b1;
      #1 chk("pop2", 128'(bif.InPort_q), 128'(32'hA0 + i));
      cyc();
    end
    idle();
    chk("empty2", 128'(bif.in_empty[2]), 128'(1));

    // Underflow on empty ch1, then clear all flags.
    bif.ch_sel = 2'd1;
    bif.InPortOut = 1'b1;
    #1 chk("udf_q", 128'(bif.InPort_q), 128'(0));
    cyc();
    idle();
    chk("underflow1", 128'(bif.flags[5]), 128'(1));
    bif.clr_flags = 1'b1;
    cyc();
    idle();
    chk("clr_flags", 128'(bif.flags), 128'(0));

    // Output ch0: load, hold, overrun.
    bif.ch_sel = 2'd0;
    bif.OutPortIn = 1'b1;
    bif.BusMuxOut = 32'h12345678;
    #1 chk("oval0_pre", 128'(bif.out_valid[0]), 128'(0));
    cyc();
    idle();
    chk("oval0", 128'(bif.out_valid[0]), 128'(1));
    cyc();
    cyc();
    chk("odat0_hold", 128'(bif.out_data[31:0]), 128'(32'h12345678));
    bif.OutPortIn = 1'b1;
    bif.BusMuxOut = 32'hDEAD;
    cyc();
    idle();
    chk("odat0_ovr", 128'(bif.out_data[31:0]), 128'(32'hDEAD));
    chk("overrun0", 128'(bif.flags[0]), 128'(1));
    bif.out_ack = 4'b0001;
    cyc();
    idle();
    chk("oval0_ack", 128'(bif.out_valid[0]), 128'(0));

    // Output ch3: ack and reload on the same edge.
    bif.ch_sel = 2'd3;
    bif.OutPortIn = 1'b1;
    bif.BusMuxOut = 32'h11;
    cyc();
    bif.out_ack = 4'b1000;
    bif.BusMuxOut = 32'h55;
    cyc();
    idle();
    chk("oval3", 128'(bif.out_valid[3]), 128'(1));
    chk("odat3", 128'(bif.out_data[127:96]), 128'(32'h55));
    chk("overrun3", 128'(bif.flags[9]), 128'(0));

`ifdef PORT_IRQ_EN
    bif.clr_flags = 1'b1;
    cyc();
    idle();
    irq_mask = 4'b0100;
    cyc();
    chk("irq_idle", 128'(irq), 128'(0));
    bif.in_valid = 4'b0100;
    bif.in_data[2*DW +: DW] = 32'h77;
    cyc();
    idle();
    cyc();
    chk("irq_set", 128'(irq), 128'(1));
    bif.ch_sel = 2'd2;
    bif.InPortOut = 1'b1;
    cyc();
    idle();
    cyc();
    chk("irq_clr", 128'(irq), 128'(0));
`endif

    // Reset with a pending output word and a non-empty FIFO.
    bif.in_valid = 4'b0001;
    bif.in_data[DW-1:0] = 32'hBEEF;
    cyc();
    idle();
    async_reset();
    chk("rst_empty", 128'(bif.in_empty), 128'(4'hF));

    for (int n = 0; n < 1500; n++) begin
      bif.ch_sel    = 2'($urandom_range(0, 3));
      bif.BusMuxOut = $urandom;
      for (int c = 0; c < NC; c++) bif.in_data[c*DW +: DW] = $urandom;
      bif.in_valid  = 4'($urandom) & 4'($urandom);
      bif.out_ack   = 4'($urandom);
      bif.InPortOut = ($urandom_range(0, 9) < 4);
      bif.OutPortIn = ($urandom_range(0, 9) < 3);
      bif.clr_flags = ($urandom_range(0, 15) == 0);
`ifdef PORT_IRQ_EN
      irq_mask = 4'($urandom);
`endif
      if (n == 700) async_reset();
      else cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
